// File: rtl/wb_master_pkg.sv
// rtl/wb_master_pkg.sv - cycle-type codes and FSM state type shared by the Wishbone burst master
package wb_master_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - no-ack watchdog, expired marks the last of 2^to_w-1 consecutive stalled cycles
module wb_watchdog #(
    parameter int to_w = 8
) (
    input  logic sys_clk,
    input  logic RESETN,
    input  logic en,
    input  logic clr,
    output logic expired
);

    // cnt_q holds the number of stalled cycles already completed
    localparam logic [to_w-1:0] LAST_CNT = to_w'((2 ** to_w) - 2);

    logic [to_w-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + to_w'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && !clr && (cnt_q == LAST_CNT);

endmodule

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - single-command Wishbone incrementing-burst master with stream side channels
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int dw   = 32,
    parameter int aw   = 26,
    parameter int bl   = 5,
    parameter int to_w = 8
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [aw-1:0]   cmd_addr,
    input  logic [bl-1:0]   cmd_len,
    input  logic            wdata_valid,
    output logic            wdata_ready,
    input  logic [dw-1:0]   wdata,
    input  logic [dw/8-1:0] wsel,
    output logic            rdata_valid,
    output logic [dw-1:0]   rdata,
    output logic            rdata_last,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [aw-1:0]   wb_addr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [dw-1:0]   wb_dat_i
);

    localparam int SW = dw / 8;
    localparam int CW = bl + 1;
    localparam logic [aw-1:0] STEP       = aw'(SW);
    localparam logic [aw-1:0] ALIGN_MASK = ~aw'(SW - 1);

    state_t          state_q, state_d;
    logic [aw-1:0]   addr_q, addr_d;
    logic [CW-1:0]   total_q, total_d;
    logic [CW-1:0]   issued_q, issued_d;
    logic [CW-1:0]   acked_q, acked_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [dw-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [2:0]      cti_q, cti_d;
    logic [dw-1:0]   rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            rlast_q, rlast_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            busy_q, busy_d;

    logic ack, last_ack, wr_hs, wd_en, wd_clr, wd_expired;

    // acks are only meaningful while our strobe is up
    assign ack         = stb_q && wb_ack_i;
    assign last_ack    = ack && (acked_q + CW'(1) == total_q);
    assign wdata_ready = (state_q == WRITE) && (!stb_q || wb_ack_i) && (issued_q < total_q);
    assign wr_hs       = wdata_ready && wdata_valid;
    assign wd_en       = stb_q && !wb_ack_i;
    assign wd_clr      = !stb_q || wb_ack_i;

    wb_watchdog #(
        .to_w(to_w)
    ) u_watchdog (
        .sys_clk(sys_clk),
        .RESETN (RESETN),
        .en     (wd_en),
        .clr    (wd_clr),
        .expired(wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        total_d  = total_q;
        issued_d = issued_q;
        acked_d  = acked_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        cti_d    = cti_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_ready_q && cmd_valid) begin
                    total_d  = CW'(cmd_len) + CW'(1);
                    issued_d = '0;
                    acked_d  = '0;
                    addr_d   = cmd_addr & ALIGN_MASK;
                    we_d     = cmd_we;
                    cyc_d    = 1'b1;
                    if (cmd_we) begin
                        state_d = WRITE;
                        stb_d   = 1'b0;
                        cti_d   = CTI_CLASSIC;
                    end else begin
                        state_d = READ;
                        stb_d   = 1'b1;
                        cti_d   = (cmd_len == '0) ? CTI_EOB : CTI_INCR;
                    end
                end
            end
            WRITE: begin
                if (ack) begin
                    acked_d = acked_q + CW'(1);
                    addr_d  = addr_q + STEP;
                    stb_d   = 1'b0;
                end
                // a new beat in the same cycle as an ack keeps the strobe up
                if (wr_hs) begin
                    stb_d    = 1'b1;
                    dat_d    = wdata;
                    sel_d    = wsel;
                    issued_d = issued_q + CW'(1);
                    cti_d    = (issued_q + CW'(1) == total_q) ? CTI_EOB : CTI_INCR;
                end
            end
            READ: begin
                if (ack) begin
                    acked_d  = acked_q + CW'(1);
                    addr_d   = addr_q + STEP;
                    rdata_d  = wb_dat_i;
                    rvalid_d = 1'b1;
                    rlast_d  = last_ack;
                    cti_d    = (acked_q + CW'(2) == total_q) ? CTI_EOB : CTI_INCR;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (last_ack) begin
            state_d = FINISH;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            cti_d   = CTI_CLASSIC;
        end

        if (wd_expired) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            cti_d   = CTI_CLASSIC;
            err_d   = 1'b1;
        end

        done_d      = (state_d == FINISH);
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            total_q     <= '0;
            issued_q    <= '0;
            acked_q     <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            dat_q       <= '0;
            sel_q       <= '0;
            cti_q       <= CTI_CLASSIC;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            total_q     <= total_d;
            issued_q    <= issued_d;
            acked_q     <= acked_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            cti_q       <= cti_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rdata_valid = rvalid_q;
    assign rdata       = rdata_q;
    assign rdata_last  = rlast_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_addr_o   = addr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign wb_cti_o    = cti_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - scoreboard bench for wb_burst_master with directed and randomized bursts
module tb_wb_burst_master;

    localparam int DW   = 32;
    localparam int AW   = 26;
    localparam int BL   = 5;
    localparam int TO_W = 4;
    localparam int SW   = DW / 8;

    localparam int ACK_ALWAYS = 0;
    localparam int ACK_RAND   = 1;
    localparam int ACK_NEVER  = 2;

    logic          sys_clk = 1'b0;
    logic          RESETN = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [BL-1:0] cmd_len = '0;
    logic          wdata_valid = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wsel = '0;
    logic          wb_ack_i = 1'b0;
    logic [DW-1:0] wb_dat_i;
    logic          cmd_ready, wdata_ready, rdata_valid, rdata_last, busy, done, err;
    logic [DW-1:0] rdata;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic [2:0]    wb_cti_o;

    wb_burst_master #(.dw(DW), .aw(AW), .bl(BL), .to_w(TO_W)) dut (
        .sys_clk(sys_clk), .RESETN(RESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wsel(wsel),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
        .busy(busy), .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic [2:0]    cti;
    } beat_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic          last;
    } rbeat_t;

    beat_t      exp_bus[$];
    rbeat_t     exp_rd[$];
    logic [1:0] exp_evt[$];
    int         beat_cyc[$];
    bit         ack_pat[$];

    int errors = 0;
    int checks = 0;
    int cycle_n = 0;
    int nbeats = 0;
    int ack_mode = ACK_ALWAYS;
    int miss = 0;
    bit saw_wait = 0;

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
        return {a[15:0], 16'hA000 ^ a[25:10]};
    endfunction

    assign wb_dat_i = rd_word(wb_addr_o);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_true(input string name, input bit cond);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s: got 0 expected 1", name);
        end
    endtask

    always @(posedge sys_clk) cycle_n <= cycle_n + 1;

    // slave: random, scripted or absent acks; spurious acks while strobe is low in random mode
    initial forever begin
        @(posedge sys_clk);
        #1;
        if (wb_cyc_o && wb_stb_o) begin
            if (ack_pat.size() > 0) wb_ack_i = ack_pat.pop_front();
            else if (ack_mode == ACK_NEVER) wb_ack_i = 1'b0;
            else if (ack_mode == ACK_RAND) wb_ack_i = (miss >= 3) || ($urandom_range(0, 1) == 1);
            else wb_ack_i = 1'b1;
            miss = wb_ack_i ? 0 : miss + 1;
        end else begin
            wb_ack_i = (ack_mode == ACK_RAND) && ($urandom_range(0, 3) == 0);
            miss = 0;
        end
    end

    // monitor: pops the scoreboard whenever the DUT presents a beat, read data or an end event
    initial begin
        bit     beat;
        bit     prev_rd_beat;
        int     stall;
        beat_t  b;
        rbeat_t r;
        prev_rd_beat = 0;
        stall = 0;
        forever begin
            @(negedge sys_clk);
            if (!RESETN) begin
                prev_rd_beat = 0;
                stall = 0;
            end else begin
                beat = wb_cyc_o && wb_stb_o && wb_ack_i;
                if (!wb_cyc_o) begin
                    chk("idle_stb", wb_stb_o, 0);
                    chk("idle_cti", wb_cti_o, 0);
                end
                if (beat) begin
                    nbeats++;
                    beat_cyc.push_back(cycle_n);
                    chk_true("bus_expected", exp_bus.size() > 0);
                    if (exp_bus.size() > 0) begin
                        b = exp_bus.pop_front();
                        chk("wb_we", wb_we_o, b.we);
                        chk("wb_addr", wb_addr_o, b.addr);
                        chk("wb_cti", wb_cti_o, b.cti);
                        if (b.we) begin
                            chk("wb_dat", wb_dat_o, b.dat);
                            chk("wb_sel", wb_sel_o, b.sel);
                        end
                    end
                end
                if (rdata_valid) begin
                    chk_true("rd_latency", prev_rd_beat);
                    chk_true("rd_expected", exp_rd.size() > 0);
                    if (exp_rd.size() > 0) begin
                        r = exp_rd.pop_front();
                        chk("rdata", rdata, r.dat);
                        chk("rdata_last", rdata_last, r.last);
                    end
                end
                if (done || err) begin
                    chk_true("evt_expected", exp_evt.size() > 0);
                    if (exp_evt.size() > 0) chk("done_err", {done, err}, exp_evt.pop_front());
                    chk("end_cyc", wb_cyc_o, 0);
                    if (err) begin
                        chk("wd_stall_cycles", stall, 15);
                        chk("err_cmd_ready", cmd_ready, 1);
                    end
                end
                prev_rd_beat = beat && !wb_we_o;
                stall = (wb_cyc_o && wb_stb_o && !wb_ack_i) ? stall + 1 : 0;
            end
        end
    end

    // gap_mode: 0 valid every cycle, 1 random, 2 three idle cycles after each beat
    task automatic run_burst(input bit we, input logic [AW-1:0] addr, input int len,
                             input int gap_mode, input int rst_beat);
        logic [DW-1:0] wd[$];
        logic [SW-1:0] ws[$];
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        beat_t         b;
        int widx, gapc, n;
        bit sent, fin;
        widx = 0; gapc = 0; n = 0; sent = 0; fin = 0;
        beat_cyc.delete();
        nbeats = 0;
        saw_wait = 0;
        base = addr & ~AW'(SW - 1);
        for (int k = 0; k <= len; k++) begin
            a = base + AW'(k * SW);
            b.we   = we;
            b.addr = a;
            b.dat  = we ? DW'($urandom) : '0;
            b.sel  = we ? SW'($urandom) : '0;
            b.cti  = (k == len) ? 3'b111 : 3'b010;
            wd.push_back(b.dat);
            ws.push_back(b.sel);
            if (ack_mode != ACK_NEVER) begin
                exp_bus.push_back(b);
                if (!we) exp_rd.push_back('{dat: rd_word(a), last: (k == len)});
            end
        end
        exp_evt.push_back((ack_mode == ACK_NEVER) ? 2'b01 : 2'b10);

        while (!fin && n < 1000) begin
            @(posedge sys_clk);
            #1;
            cmd_valid = 1'b0;
            if (!sent && cmd_ready) begin
                cmd_valid = 1'b1;
                cmd_we    = we;
                cmd_addr  = addr;
                cmd_len   = BL'(len);
                sent      = 1;
            end else if (!cmd_ready && $urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b1;
                cmd_we    = 1'($urandom);
                cmd_addr  = AW'($urandom);
                cmd_len   = BL'($urandom);
            end
            wdata_valid = 1'b0;
            if (we && sent && widx <= len) begin
                if (gapc > 0) gapc--;
                else if (gap_mode != 1 || $urandom_range(0, 1) == 1) begin
                    wdata_valid = 1'b1;
                    wdata       = wd[widx];
                    wsel        = ws[widx];
                end
            end
            @(negedge sys_clk);
            #1;
            if (wdata_valid && wdata_ready) begin
                widx++;
                if (gap_mode == 2) gapc = 3;
            end
            if (we && widx > 0 && wb_cyc_o && !wb_stb_o) saw_wait = 1;
            if (done || err) fin = 1;
            if (rst_beat > 0 && nbeats >= rst_beat) begin
                RESETN = 1'b0;
                #1;
                chk("rst_cyc", wb_cyc_o, 0);
                chk("rst_stb", wb_stb_o, 0);
                chk("rst_rvalid", rdata_valid, 0);
                chk("rst_busy", busy, 0);
                exp_bus.delete();
                exp_rd.delete();
                exp_evt.delete();
                @(posedge sys_clk);
                #2;
                RESETN = 1'b1;
                chk("rst_cmd_ready_low", cmd_ready, 0);
                @(posedge sys_clk);
                #1;
                chk("rst_cmd_ready", cmd_ready, 1);
                fin = 1;
            end
            n++;
        end
        cmd_valid   = 1'b0;
        wdata_valid = 1'b0;
        chk_true("burst_finished", fin);
    endtask

    initial begin
        logic [AW-1:0] raddr;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_cti", wb_cti_o, 0);
        chk("rst_addr", wb_addr_o, 0);
        chk("rst_done_err", {done, err, rdata_valid}, 0);
        RESETN = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        ack_mode = ACK_ALWAYS;
        run_burst(1'b1, 26'h100, 3, 0, 0);
        chk("t1_beats", beat_cyc.size(), 4);
        if (beat_cyc.size() == 4) chk("t1_back_to_back", beat_cyc[3] - beat_cyc[0], 3);

        ack_pat = '{1, 1, 0, 0, 1, 1};
        run_burst(1'b0, 26'h100, 3, 0, 0);
        chk("t2_beats", beat_cyc.size(), 4);
        if (beat_cyc.size() == 4) chk("t2_ack_spacing", beat_cyc[3] - beat_cyc[0], 5);

        run_burst(1'b1, 26'h200, 1, 2, 0);
        chk("t3_wait_state", saw_wait, 1);

        run_burst(1'b1, 26'h3FFFFFC, 0, 0, 0);
        run_burst(1'b0, 26'h3FFFFFC, 1, 0, 0);

        ack_mode = ACK_NEVER;
        run_burst(1'b0, 26'h40, 3, 0, 0);
        ack_mode = ACK_ALWAYS;

        run_burst(1'b0, 26'h1000, 3, 0, 2);

        ack_mode = ACK_RAND;
        for (int i = 0; i < 40; i++) begin
            raddr = ($urandom_range(0, 3) == 0) ? AW'(26'h3FFFF00 + AW'($urandom_range(0, 255)))
                                                : AW'($urandom);
            run_burst(1'($urandom), raddr, $urandom_range(0, 31), 1, 0);
        end
        ack_mode = ACK_ALWAYS;
        repeat (4) @(posedge sys_clk);

        chk("leftover_bus", exp_bus.size(), 0);
        chk("leftover_rd", exp_rd.size(), 0);
        chk("leftover_evt", exp_evt.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
